// File: rtl/pwm_pkg.sv
// Constants and types shared by the PWM sequencer and the PWM decoder.
// Widths are fixed by the decoder's count tables.
package pwm_pkg;

  localparam int SEL_W = 3;
  localparam int CNT_W = 12;

  localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_e;

  // One period/compare pair exactly as produced by the decoder.
  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
  } counts_t;

endpackage

// File: rtl/sel_updown.sv
// Saturating up/down selection register for one decoder channel.
// The changed output flags a request that will alter the selection on the next edge.
module sel_updown
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             dn,
  output logic [SEL_W-1:0] sel,
  output logic             changed
);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;

  // Simultaneous up and down cancel; requests at a limit are dropped.
  always_comb begin
    sel_d = sel_q;
    if (up && !dn && (sel_q != SEL_MAX)) begin
      sel_d = sel_q + 1'b1;
    end else if (dn && !up && (sel_q != '0)) begin
      sel_d = sel_q - 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel     = sel_q;
  assign changed = (sel_d != sel_q);

endmodule

// File: rtl/pwm_sequencer.sv
// Sequencing controller for the PWM decoder: owns the selections, runs the
// period counter and applies new decoder counts only at a period boundary.
module pwm_sequencer
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cur_up,
  input  logic             cur_dn,
  input  logic             frq_up,
  input  logic             frq_dn,
  output logic [SEL_W-1:0] corriente_sel,
  output logic [SEL_W-1:0] frecuencia_sel,
  output logic             deco_enable,
  input  logic [CNT_W-1:0] corriente_cnt,
  input  logic [CNT_W-1:0] frecuencia_cnt,
  output logic             pwm_out,
  output logic             period_done,
  output logic             update_pending
);

  logic cur_changed;
  logic frq_changed;

  sel_updown u_cur_sel (
    .clk     (clk),
    .rst_n   (rst_n),
    .up      (cur_up),
    .dn      (cur_dn),
    .sel     (corriente_sel),
    .changed (cur_changed)
  );

  sel_updown u_frq_sel (
    .clk     (clk),
    .rst_n   (rst_n),
    .up      (frq_up),
    .dn      (frq_dn),
    .sel     (frecuencia_sel),
    .changed (frq_changed)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  counts_t          active_q, active_d;
  counts_t          shadow_q, shadow_d;
  logic             update_pending_q, update_pending_d;
  logic             arm_q, arm_d;
  logic             captured_q, captured_d;
  logic             deco_enable_q, deco_enable_d;
  logic             pwm_q, pwm_d;
  logic             period_done_q, period_done_d;

  counts_t deco_counts;
  logic    chg_in_run;
  logic    wrap;

  assign deco_counts = '{period: frecuencia_cnt, duty: corriente_cnt};
  assign chg_in_run  = (cur_changed || frq_changed) && (state_q == RUN);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    active_d         = active_q;
    shadow_d         = shadow_q;
    update_pending_d = update_pending_q;
    captured_d       = captured_q;
    arm_d            = 1'b0;
    wrap             = 1'b0;

    unique case (state_q)
      OFF: begin
        cnt_d = '0;
        if (run) state_d = START;
      end
      START: begin
        cnt_d = '0;
        if (!run) begin
          state_d = OFF;
        end else begin
          state_d          = RUN;
          active_d         = deco_counts;
          shadow_d         = deco_counts;
          update_pending_d = 1'b0;
          captured_d       = 1'b0;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = OFF;
          cnt_d   = '0;
        end else if (active_q.period == '0) begin
          cnt_d = '0;
        end else if (cnt_q >= active_q.period - 1'b1) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase

    // The decoder has had one cycle to settle on the new selection.
    if ((state_q == RUN) && arm_q && update_pending_q) begin
      shadow_d   = deco_counts;
      captured_d = 1'b1;
    end

    if (wrap && update_pending_q && captured_q) begin
      active_d         = shadow_q;
      update_pending_d = 1'b0;
      captured_d       = 1'b0;
    end

    // A fresh change outranks an apply on the same edge and re-arms capture.
    if (chg_in_run) begin
      update_pending_d = 1'b1;
      captured_d       = 1'b0;
      arm_d            = 1'b1;
    end

    // Outputs are registered from next-state values so they line up with cnt.
    deco_enable_d = (state_d != OFF);
    pwm_d         = (state_d == RUN) && (active_d.period != '0) &&
                    (cnt_d < active_d.duty);
    period_done_d = (state_d == RUN) && (active_d.period != '0) &&
                    (cnt_d == active_d.period - 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= OFF;
      cnt_q            <= '0;
      active_q         <= '0;
      shadow_q         <= '0;
      update_pending_q <= 1'b0;
      arm_q            <= 1'b0;
      captured_q       <= 1'b0;
      deco_enable_q    <= 1'b0;
      pwm_q            <= 1'b0;
      period_done_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      active_q         <= active_d;
      shadow_q         <= shadow_d;
      update_pending_q <= update_pending_d;
      arm_q            <= arm_d;
      captured_q       <= captured_d;
      deco_enable_q    <= deco_enable_d;
      pwm_q            <= pwm_d;
      period_done_q    <= period_done_d;
    end
  end

  assign deco_enable    = deco_enable_q;
  assign pwm_out        = pwm_q;
  assign period_done    = period_done_q;
  assign update_pending = update_pending_q;

endmodule
